// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding an 8-bit ALU: 4x8 register file, EX->ISSUE forwarding, writeback.
// Latency: accept at edge N drives alu_* after N; writeback at edge N+1. One instruction per cycle.
// Backpressure: instr_ready = ~stall; stall freezes ISSUE and EX state and suppresses writeback.
module alu_issue_stage #(
    parameter int NREGS = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [1:0]       instr_rd,
    input  logic [1:0]       instr_rs1,
    input  logic [1:0]       instr_rs2,
    input  logic             instr_imm_en,
    input  logic [7:0]       instr_imm,
    input  logic             stall,
    output logic [2:0]       alu_control,
    output logic [7:0]       alu_src_a,
    output logic [7:0]       alu_src_b,
    input  logic [7:0]       alu_result,
    output logic             wb_valid,
    output logic [1:0]       wb_rd,
    output logic [7:0]       wb_data,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retire_count,
    input  logic [1:0]       dbg_addr,
    output logic [7:0]       dbg_data
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ILL = 3'b100;

    logic [7:0] regs [NREGS];
    logic       ex_valid;
    logic       ex_wr;
    logic [1:0] ex_rd;

    logic       accept;
    logic       wb_fire;
    logic [7:0] fwd_a;
    logic [7:0] fwd_b;

    assign instr_ready = ~stall;
    assign accept      = instr_valid & ~stall;
    assign wb_fire     = ex_valid & ex_wr & ~stall;
    assign dbg_data    = regs[dbg_addr];

    // The EX result lands in the regfile on the same edge the dependent op issues, so bypass it.
    always_comb begin
        fwd_a = regs[instr_rs1];
        fwd_b = regs[instr_rs2];
        if (wb_fire && ex_rd == instr_rs1) fwd_a = alu_result;
        if (wb_fire && ex_rd == instr_rs2) fwd_b = alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            alu_control  <= OP_NOP;
            alu_src_a    <= '0;
            alu_src_b    <= '0;
            ex_valid     <= 1'b0;
            ex_wr        <= 1'b0;
            ex_rd        <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            illegal_op   <= 1'b0;
            retire_count <= '0;
        end else begin
            if (accept) begin
                alu_control <= instr_op;
                alu_src_a   <= fwd_a;
                alu_src_b   <= instr_imm_en ? instr_imm : fwd_b;
                ex_rd       <= instr_rd;
                ex_valid    <= 1'b1;
                ex_wr       <= (instr_op != OP_NOP) && (instr_op != OP_ILL);
                if (instr_op == OP_ILL) illegal_op <= 1'b1;
            end else if (!stall) begin
                ex_valid    <= 1'b0;
                alu_control <= OP_NOP;
            end

            if (wb_fire) begin
                regs[ex_rd]  <= alu_result;
                wb_valid     <= 1'b1;
                wb_rd        <= ex_rd;
                wb_data      <= alu_result;
                retire_count <= retire_count + CNT_W'(1);
            end else begin
                wb_valid     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed table-driven bench for alu_issue_stage with a behavioural ALU closing the loop.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap quickly.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic       stall;
    logic [2:0] alu_control;
    logic [7:0] alu_src_a, alu_src_b, alu_result;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       illegal_op;
    logic [15:0] retire_count;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    logic       ready_w;
    logic [2:0] ctl_w;
    logic [7:0] a_w, b_w, res_w;
    logic       wbv_w;
    logic [1:0] wbr_w;
    logic [7:0] wbd_w;
    logic       ill_w;
    logic [3:0] rc_w;
    logic [7:0] dbg_w;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        case (c)
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b011:  return a ^ b;
            3'b101:  return a + b;
            3'b110:  return a - b;
            3'b111:  return p[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_control, alu_src_a, alu_src_b);
    always_comb res_w      = alu_f(ctl_w, a_w, b_w);

    alu_issue_stage #(.NREGS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm), .stall(stall),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal_op(illegal_op), .retire_count(retire_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu_issue_stage #(.NREGS(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(ready_w),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm), .stall(stall),
        .alu_control(ctl_w), .alu_src_a(a_w), .alu_src_b(b_w),
        .alu_result(res_w), .wb_valid(wbv_w), .wb_rd(wbr_w), .wb_data(wbd_w),
        .illegal_op(ill_w), .retire_count(rc_w), .dbg_addr(dbg_addr), .dbg_data(dbg_w)
    );

    typedef struct {
        logic       vld;
        logic [2:0] op;
        logic [1:0] rd, rs1, rs2;
        logic       ie;
        logic [7:0] imm;
        logic       st;
        logic [2:0] e_ctl;
        logic [7:0] e_a, e_b;
        logic       e_wv;
        logic [1:0] e_wr;
        logic [7:0] e_wd;
        int         e_cnt;
        logic       e_ill;
        logic [7:0] e_dbg;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ie, input logic [7:0] imm, input logic st);
        instr_valid  = v;
        instr_op     = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        instr_imm_en = ie;
        instr_imm    = imm;
        stall        = st;
    endtask

    initial begin
        //          vld op rd s1 s2 ie imm  st  ctl a    b    wv wr wd   cnt ill dbg
        tbl[0]  = '{1, 5, 1, 0, 0, 1, 5,   0,  5,  0,   5,   0, 0, 0,   0,  0,  0};
        tbl[1]  = '{1, 5, 2, 0, 0, 1, 3,   0,  5,  0,   3,   1, 1, 5,   1,  0,  0};
        tbl[2]  = '{1, 5, 3, 1, 2, 0, 0,   0,  5,  5,   3,   1, 2, 3,   2,  0,  0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,   0,  0,  5,   3,   1, 3, 8,   3,  0,  8};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,   0,  0,  5,   3,   0, 3, 8,   3,  0,  8};
        tbl[5]  = '{1, 5, 1, 0, 0, 1, 200, 0,  5,  0,   200, 0, 3, 8,   3,  0,  8};
        tbl[6]  = '{1, 5, 1, 1, 0, 1, 100, 0,  5,  200, 100, 1, 1, 200, 4,  0,  8};
        tbl[7]  = '{1, 6, 2, 0, 1, 0, 0,   0,  6,  0,   44,  1, 1, 44,  5,  0,  8};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,   0,  0,  0,   44,  1, 2, 212, 6,  0,  8};
        tbl[9]  = '{1, 5, 1, 0, 0, 1, 7,   0,  5,  0,   7,   0, 2, 212, 6,  0,  8};
        tbl[10] = '{1, 7, 1, 1, 0, 1, 9,   0,  7,  7,   9,   1, 1, 7,   7,  0,  8};
        tbl[11] = '{1, 1, 2, 0, 0, 1, 1,   1,  7,  7,   9,   0, 1, 7,   7,  0,  8};
        tbl[12] = '{1, 1, 2, 0, 0, 1, 1,   1,  7,  7,   9,   0, 1, 7,   7,  0,  8};
        tbl[13] = '{1, 1, 2, 0, 0, 1, 1,   1,  7,  7,   9,   0, 1, 7,   7,  0,  8};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0,   0,  0,  7,   9,   1, 1, 63,  8,  0,  8};
        tbl[15] = '{1, 0, 3, 1, 1, 0, 0,   0,  0,  63,  63,  0, 1, 63,  8,  0,  8};
        tbl[16] = '{1, 4, 2, 0, 0, 1, 1,   0,  4,  0,   1,   0, 1, 63,  8,  1,  8};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0,   0,  0,  0,   1,   0, 1, 63,  8,  1,  8};
        tbl[18] = '{1, 5, 2, 0, 0, 1, 1,   0,  5,  0,   1,   0, 1, 63,  8,  1,  8};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 0,   0,  0,  0,   1,   1, 2, 1,   9,  1,  8};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        dbg_addr = 2'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst ready", 32'(instr_ready), 1);
        chk("rst ctl", 32'(alu_control), 0);
        chk("rst src_a", 32'(alu_src_a), 0);
        chk("rst src_b", 32'(alu_src_b), 0);
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst wb_rd", 32'(wb_rd), 0);
        chk("rst wb_data", 32'(wb_data), 0);
        chk("rst illegal", 32'(illegal_op), 0);
        chk("rst count", 32'(retire_count), 0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk($sformatf("rst reg%0d", r), 32'(dbg_data), 0);
        end
        dbg_addr = 2'd3;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].vld, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].ie, tbl[i].imm, tbl[i].st);
            #1;
            chk($sformatf("v%0d ready", i), 32'(instr_ready), 32'(!tbl[i].st));
            tick();
            chk($sformatf("v%0d ctl", i), 32'(alu_control), 32'(tbl[i].e_ctl));
            chk($sformatf("v%0d src_a", i), 32'(alu_src_a), 32'(tbl[i].e_a));
            chk($sformatf("v%0d src_b", i), 32'(alu_src_b), 32'(tbl[i].e_b));
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wv));
            chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d wb_data", i), 32'(wb_data), 32'(tbl[i].e_wd));
            chk($sformatf("v%0d count", i), 32'(retire_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d count4", i), 32'(rc_w), 32'(tbl[i].e_cnt % 16));
            chk($sformatf("v%0d illegal", i), 32'(illegal_op), 32'(tbl[i].e_ill));
            chk($sformatf("v%0d dbg_r3", i), 32'(dbg_data), 32'(tbl[i].e_dbg));
        end

        // Reset arriving while an XOR sits in EX must discard it.
        dbg_addr = 2'd1;
        drive(1, 5, 1, 0, 0, 1, 8'hF0, 0);
        tick();
        drive(1, 3, 1, 1, 0, 1, 8'hFF, 0);
        tick();
        chk("xor ctl", 32'(alu_control), 3);
        chk("xor src_a fwd", 32'(alu_src_a), 32'h F0);
        chk("xor src_b", 32'(alu_src_b), 32'h FF);
        chk("xor pre-rst r1", 32'(dbg_data), 32'h F0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-rst wb_valid", 32'(wb_valid), 0);
        chk("mid-rst wb_rd", 32'(wb_rd), 0);
        chk("mid-rst wb_data", 32'(wb_data), 0);
        chk("mid-rst ctl", 32'(alu_control), 0);
        chk("mid-rst src_a", 32'(alu_src_a), 0);
        chk("mid-rst src_b", 32'(alu_src_b), 0);
        chk("mid-rst illegal", 32'(illegal_op), 0);
        chk("mid-rst count", 32'(retire_count), 0);
        chk("mid-rst r1", 32'(dbg_data), 0);
        tick();
        chk("post-rst wb_valid", 32'(wb_valid), 0);
        chk("post-rst r1", 32'(dbg_data), 0);
        chk("post-rst count", 32'(retire_count), 0);

        // Sixteen back-to-back ADDs: the 4-bit counter wraps, the 16-bit one reaches 16.
        for (int k = 1; k <= 16; k++) begin
            drive(1, 5, 2, 0, 0, 1, 8'(k), 0);
            tick();
            if (k > 1) begin
                chk($sformatf("wrap%0d wb_data", k), 32'(wb_data), 32'(k - 1));
                chk($sformatf("wrap%0d count", k), 32'(retire_count), 32'(k - 1));
                chk($sformatf("wrap%0d count4", k), 32'(rc_w), 32'(k - 1));
                chk($sformatf("wrap%0d wb4", k), 32'({wbv_w, wbd_w}), 32'({1'b1, 8'(k - 1)}));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wrap wb_data", 32'(wb_data), 16);
        chk("wrap count16", 32'(retire_count), 16);
        chk("wrap count4 to zero", 32'(rc_w), 0);
        chk("wrap illegal4", 32'(ill_w), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Operand-fetch/issue stage directly upstream of the 8-bit ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from a 4-entry x 8-bit register file. It drives registered Control/SrcA/SrcB into the ALU, then writes the ALU result back into the register file. Pipeline is two stages: ISSUE (accept, operand read) -> EX (ALU evaluates, writeback at end of cycle). EX-to-ISSUE forwarding is included.

Parameters:
NREGS, 4, register-file depth; fixed at 4 because register indices are 2 bits
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  stage can accept; equals ~stall
instr_op  input  3  ALU control code: 001 AND, 010 OR, 011 XOR, 101 ADD, 110 SUB, 111 MUL, 000 NOP, 100 illegal
instr_rd  input  2  destination register
instr_rs1  input  2  source A register
instr_rs2  input  2  source B register
instr_imm_en  input  1  1: SrcB = instr_imm instead of rs2
instr_imm  input  8  immediate operand
stall  input  1  freezes ISSUE and EX registers
alu_control  output  3  to ALU Control
alu_src_a  output  8  to ALU SrcA
alu_src_b  output  8  to ALU SrcB
alu_result  input  8  from ALU result (combinational from alu_* outputs)
wb_valid  output  1  one-cycle pulse: writeback occurred
wb_rd  output  2  register written
wb_data  output  8  value written
illegal_op  output  1  sticky; set when op 100 is accepted
retire_count  output  CNT_W  count of writebacks, wraps at 2^CNT_W
dbg_addr  input  2  debug register-file read address
dbg_data  output  8  combinational read of regfile[dbg_addr]; no forwarding

Behaviour:
- Reset (rst=1 at posedge): all 4 registers = 0. alu_control = 000, alu_src_a = alu_src_b = 0, ex_valid = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, illegal_op = 0, retire_count = 0. Reset overrides stall and any in-flight instruction; that instruction is discarded with no writeback.
- Accept: instruction accepted on a posedge where instr_valid & instr_ready. instr_ready = ~stall combinationally; it does not depend on instr_valid.
- ISSUE -> EX (on accept):
  - alu_control <= instr_op.
  - alu_src_a <= fwd(rs1).
  - alu_src_b <= instr_imm_en ? instr_imm : fwd(rs2).
  - ex_rd <= rd; ex_valid <= 1; ex_wr <= (op not in {000, 100}).
- No accept and no stall: ex_valid <= 0 and alu_control <= 000. Operand registers hold their values.
- Forwarding: fwd(r) = alu_result if (ex_valid & ex_wr & ex_rd == r & ~stall), else regfile[r]. Writeback and issue occur on the same edge, so this removes all RAW hazards for back-to-back dependent instructions.
- EX writeback, on a posedge with ex_valid & ex_wr & ~stall:
  - regfile[ex_rd] <= alu_result.
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_result.
  - retire_count increments.
  - Otherwise wb_valid <= 0; wb_rd and wb_data hold.
- Latency: instruction accepted at edge N; ALU operands valid after N; result written at edge N+1; wb_valid high during cycle N+1..N+2. Throughput is 1 instruction/cycle.
- NOP (000): occupies EX, no writeback, no count.
- Illegal (100): occupies EX, no writeback, no count; illegal_op <= 1 until reset.
- Stall=1: ISSUE and EX registers hold; no accept, no writeback, wb_valid <= 0. The held EX instruction writes back on the first edge with stall=0.
- Arithmetic: results are whatever the ALU returns (8-bit, modulo 256). This stage does no width extension.
- Same-edge conflict: a writeback and the debug read of the same register are allowed; dbg_data shows the old value until the edge.

Test Plan:
- Reset then load: issue ADD r1 = r0 + imm 5, then ADD r2 = r0 + imm 3, then ADD r3 = r1 + r2 -> wb sequence (r1,5), (r2,3), (r3,8) on consecutive cycles; retire_count = 3; dbg_addr=3 reads 8.
- Forwarding chain: r1=200 (imm), ADD r1 = r1 + imm 100 back-to-back -> second op sees SrcA = 200 via forward; wb_data = 44; then SUB r2 = r0 - r1 -> 212.
- Stall mid-flight: accept MUL r1 = imm-loaded 7 x 9, then raise stall for 3 cycles -> instr_ready = 0, wb_valid = 0 during stall, alu_* stable; writeback (r1,63) on first edge after stall drops.
- NOP/illegal: issue op 000 then op 100 -> no wb_valid, retire_count unchanged, illegal_op = 1 and sticky across later valid ops until rst.
- Reset mid-operation: accept XOR r1 = 0xF0 ^ 0xFF, assert rst on the following edge -> no writeback, r1 = 0, all outputs at reset values.
- Wrap: preset retire_count to 0xFFFF via 65535 writebacks (or force), one more ADD -> retire_count = 0x0000.
